// File: rtl/mul_share_arb.sv
// mul_share_arb: round-robin scheduler sharing one serial 32x32 multiplier among NREQ requesters.
// Latency: gnt/m_start one cycle after req is seen in IDLE; result one cycle after the first m_done seen in WAIT.
// Backpressure: the result is held until res_ready; no new grant is issued while a result is pending.
// Optional feature macro: MUL_SHARE_ARB_TIMEOUT_EN adds res_err and a WAIT watchdog of TIMEOUT cycles.
module mul_share_arb #(
    parameter int NREQ    = 4,
    parameter int IDW     = 3,
    parameter int TIMEOUT = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*32-1:0]  req_mc,
    input  logic [NREQ*32-1:0]  req_mp,
    output logic [NREQ-1:0]     gnt,
    output logic                m_start,
    output logic [31:0]         m_mc,
    output logic [31:0]         m_mp,
    input  logic [63:0]         m_p,
    input  logic                m_done,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [IDW-1:0]      res_id,
    output logic [63:0]         res_p,
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
    output logic                res_err,
`endif
    output logic                busy
);

    // One extra bit so rr+offset and index+NREQ never overflow during the search.
    localparam int IW  = IDW + 1;
    localparam int WCW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_START  = 2'd1,
        S_WAIT   = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] rr;
    logic [IDW-1:0] cur_id;
    logic [WCW-1:0] wc;

    logic [IDW-1:0] win;
    logic           win_ok;
    logic [31:0]    sel_mc;
    logic [31:0]    sel_mp;

    // Round-robin search: walk offsets from rr upward, first asserted request wins, operands muxed alongside.
    always_comb begin
        win    = '0;
        win_ok = 1'b0;
        sel_mc = '0;
        sel_mp = '0;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!win_ok && req[j] &&
                    ((IW'(j) == ({1'b0, rr} + IW'(k))) ||
                     ((IW'(j) + IW'(NREQ)) == ({1'b0, rr} + IW'(k))))) begin
                    win_ok = 1'b1;
                    win    = IDW'(j);
                    sel_mc = req_mc[32*j +: 32];
                    sel_mp = req_mp[32*j +: 32];
                end
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; m_done is only looked at in WAIT because it may still be high from the previous run.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (win_ok) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) begin
                    state_nxt = S_RESULT;
                end
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
                else if (wc >= WCW'(TIMEOUT)) begin
                    state_nxt = S_RESULT;
                end
`endif
            end
            S_RESULT: begin
                if (res_valid && res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered outputs and datapath; operands only change on a grant so the multiplier inputs never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt       <= '0;
            m_start   <= 1'b0;
            m_mc      <= '0;
            m_mp      <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_p     <= '0;
            busy      <= 1'b0;
            rr        <= '0;
            cur_id    <= '0;
            wc        <= '0;
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
            res_err   <= 1'b0;
`endif
        end else begin
            gnt     <= '0;
            m_start <= 1'b0;
            busy    <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (win_ok) begin
                        m_mc    <= sel_mc;
                        m_mp    <= sel_mp;
                        cur_id  <= win;
                        gnt     <= NREQ'(1) << win;
                        m_start <= 1'b1;
                    end
                end
                S_START: begin
                    wc <= '0;
                end
                S_WAIT: begin
                    if (wc != {WCW{1'b1}}) begin
                        wc <= wc + WCW'(1);
                    end
                    if (m_done) begin
                        res_p     <= m_p;
                        res_id    <= cur_id;
                        res_valid <= 1'b1;
                    end
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
                    else if (wc >= WCW'(TIMEOUT)) begin
                        res_p     <= '0;
                        res_id    <= cur_id;
                        res_err   <= 1'b1;
                        res_valid <= 1'b1;
                    end
`endif
                end
                S_RESULT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
`ifdef MUL_SHARE_ARB_TIMEOUT_EN
                        res_err   <= 1'b0;
`endif
                        rr        <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
